// File: rtl/aes_uart_pkg.sv
// Shared types and constants for the AES UART host initiator.
package aes_uart_pkg;

   typedef enum logic [1:0] {IDLE, SEND, RECV, DONE} state_t;

   localparam int unsigned AES_BLOCK_BYTES = 16;
   localparam logic [7:0]  UART_CR         = 8'h0D;

   // True when any byte of the block equals the carriage-return terminator.
   function automatic logic block_has_cr(input logic [127:0] blk);
      logic hit;
      hit = 1'b0;
      for (int i = 0; i < AES_BLOCK_BYTES; i++) begin
         hit = hit | (blk[i*8 +: 8] == UART_CR);
      end
      return hit;
   endfunction

endpackage

// File: rtl/uart.sv
// 8N1 UART: byte transmitter with one-cycle accept ack, mid-bit sampling receiver.
module uart #(
   parameter int unsigned CLK_HZ = 100_000_000,
   parameter int unsigned BAUD   = 115200
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] tx_data,
   input  logic       tx_data_valid,
   output logic       tx_data_ack,
   output logic       txd,
   output logic [7:0] rx_data,
   output logic       rx_data_fresh,
   input  logic       rxd
);
   localparam int unsigned DIV = CLK_HZ / BAUD;
   localparam int unsigned CW  = $clog2(DIV + 1);
   localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);
   localparam logic [CW-1:0] DIV_HALF = CW'(DIV / 2 - 1);

   logic          tx_busy;
   logic [CW-1:0] tx_div;
   logic [3:0]    tx_bits;
   logic [9:0]    tx_sr;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tx_busy     <= 1'b0;
         tx_div      <= '0;
         tx_bits     <= '0;
         tx_sr       <= '1;
         tx_data_ack <= 1'b0;
         txd         <= 1'b1;
      end else begin
         tx_data_ack <= 1'b0;
         if (!tx_busy) begin
            txd <= 1'b1;
            if (tx_data_valid) begin
               tx_busy     <= 1'b1;
               tx_sr       <= {1'b1, tx_data, 1'b0};
               tx_div      <= '0;
               tx_bits     <= '0;
               tx_data_ack <= 1'b1;
               txd         <= 1'b0;
            end
         end else if (tx_div == DIV_LAST) begin
            tx_div <= '0;
            if (tx_bits == 4'd9) begin
               tx_busy <= 1'b0;
               txd     <= 1'b1;
            end else begin
               tx_sr   <= {1'b1, tx_sr[9:1]};
               txd     <= tx_sr[1];
               tx_bits <= tx_bits + 4'd1;
            end
         end else begin
            tx_div <= tx_div + 1'b1;
         end
      end
   end

   logic [1:0]    rx_sync;
   logic          rx_busy;
   logic [CW-1:0] rx_div;
   logic [3:0]    rx_bits;
   logic [7:0]    rx_sr;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_sync       <= 2'b11;
         rx_busy       <= 1'b0;
         rx_div        <= '0;
         rx_bits       <= '0;
         rx_sr         <= '0;
         rx_data       <= '0;
         rx_data_fresh <= 1'b0;
      end else begin
         rx_sync       <= {rx_sync[0], rxd};
         rx_data_fresh <= 1'b0;
         if (!rx_busy) begin
            if (!rx_sync[1]) begin
               rx_busy <= 1'b1;
               rx_div  <= '0;
               rx_bits <= '0;
            end
         end else if (rx_bits == 4'd0) begin
            // Confirm the start bit at its midpoint; a glitch aborts the frame.
            if (rx_div == DIV_HALF) begin
               rx_div  <= '0;
               rx_busy <= ~rx_sync[1];
               rx_bits <= 4'd1;
            end else begin
               rx_div <= rx_div + 1'b1;
            end
         end else if (rx_div == DIV_LAST) begin
            rx_div <= '0;
            if (rx_bits == 4'd9) begin
               rx_busy <= 1'b0;
               if (rx_sync[1]) begin
                  rx_data       <= rx_sr;
                  rx_data_fresh <= 1'b1;
               end
            end else begin
               rx_sr   <= {rx_sync[1], rx_sr[7:1]};
               rx_bits <= rx_bits + 4'd1;
            end
         end else begin
            rx_div <= rx_div + 1'b1;
         end
      end
   end

endmodule

// File: rtl/aes_uart_host.sv
// Host-side AES UART initiator: sends a 128-bit block as 16 bytes MSB first,
// then assembles the 16-byte reply with an inter-byte timeout.
module aes_uart_host
   import aes_uart_pkg::*;
#(
   parameter int unsigned CLK_HZ         = 100_000_000,
   parameter int unsigned BAUD           = 115200,
   parameter int unsigned TIMEOUT_CYCLES = 2_000_000
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         req_valid,
   output logic         req_ready,
   input  logic [127:0] req_data,
   output logic         rsp_valid,
   output logic [127:0] rsp_data,
   output logic         rsp_timeout,
   output logic         cr_hazard,
   output logic         busy,
   output logic         uart_txd,
   input  logic         uart_rxd
);
   localparam int unsigned   TW        = $clog2(TIMEOUT_CYCLES);
   localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [4:0]    LAST_BYTE = 5'(AES_BLOCK_BYTES - 1);

   state_t         state_q, state_d;
   logic [127:0]   shift_q, shift_d;
   logic [119:0]   rx_shift_q, rx_shift_d;  // first 15 bytes; the 16th goes straight to rsp_data
   logic [4:0]     byte_cnt_q, byte_cnt_d;
   logic [TW-1:0]  to_cnt_q, to_cnt_d;
   logic           tx_valid_q, tx_valid_d;
   logic           cr_hazard_q, cr_hazard_d;
   logic [127:0]   rsp_data_q, rsp_data_d;

   logic           tx_data_valid;
   logic           tx_data_ack;
   logic [7:0]     rx_data;
   logic           rx_data_fresh;

   assign tx_data_valid = tx_valid_q;
   assign req_ready     = (state_q == IDLE);
   assign busy          = (state_q != IDLE);
   assign cr_hazard     = cr_hazard_q;
   assign rsp_data      = rsp_data_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         shift_q     <= '0;
         rx_shift_q  <= '0;
         byte_cnt_q  <= '0;
         to_cnt_q    <= '0;
         tx_valid_q  <= 1'b0;
         cr_hazard_q <= 1'b0;
         rsp_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         shift_q     <= shift_d;
         rx_shift_q  <= rx_shift_d;
         byte_cnt_q  <= byte_cnt_d;
         to_cnt_q    <= to_cnt_d;
         tx_valid_q  <= tx_valid_d;
         cr_hazard_q <= cr_hazard_d;
         rsp_data_q  <= rsp_data_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      shift_d     = shift_q;
      rx_shift_d  = rx_shift_q;
      byte_cnt_d  = byte_cnt_q;
      to_cnt_d    = to_cnt_q;
      tx_valid_d  = tx_valid_q;
      cr_hazard_d = cr_hazard_q;
      rsp_data_d  = rsp_data_q;
      rsp_valid   = 1'b0;
      rsp_timeout = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (req_valid) begin
               shift_d     = req_data;
               byte_cnt_d  = '0;
               cr_hazard_d = block_has_cr(req_data);
               tx_valid_d  = 1'b1;
               state_d     = SEND;
            end
         end
         SEND: begin
            if (tx_data_ack) begin
               tx_valid_d = 1'b0;
               shift_d    = {shift_q[119:0], 8'h00};
               if (byte_cnt_q == LAST_BYTE) begin
                  byte_cnt_d = '0;
                  to_cnt_d   = '0;
                  state_d    = RECV;
               end else begin
                  byte_cnt_d = byte_cnt_q + 5'd1;
               end
            end else if (!tx_valid_q) begin
               tx_valid_d = 1'b1;
            end
         end
         RECV: begin
            // A byte arriving on the expiry cycle wins over the timeout.
            if (rx_data_fresh) begin
               rx_shift_d = {rx_shift_q[111:0], rx_data};
               byte_cnt_d = byte_cnt_q + 5'd1;
               to_cnt_d   = '0;
               if (byte_cnt_q == LAST_BYTE) begin
                  rsp_data_d = {rx_shift_q, rx_data};
                  state_d    = DONE;
               end
            end else if (to_cnt_q == TO_LAST) begin
               rsp_timeout = 1'b1;
               byte_cnt_d  = '0;
               state_d     = IDLE;
            end else if (to_cnt_q != '1) begin
               to_cnt_d = to_cnt_q + 1'b1;
            end
         end
         DONE: begin
            rsp_valid  = 1'b1;
            byte_cnt_d = '0;
            state_d    = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   uart #(
      .CLK_HZ(CLK_HZ),
      .BAUD  (BAUD)
   ) u_uart (
      .clk          (clk),
      .rst          (rst),
      .tx_data      (shift_q[127:120]),
      .tx_data_valid(tx_data_valid),
      .tx_data_ack  (tx_data_ack),
      .txd          (uart_txd),
      .rx_data      (rx_data),
      .rx_data_fresh(rx_data_fresh),
      .rxd          (uart_rxd)
   );

endmodule

// File: tb/tb_aes_uart_host.sv
// Self-checking bench for aes_uart_host: serial decode of txd, serial drive of rxd,
// behavioural model of the block/response exchange checked every cycle.
module tb_aes_uart_host;
   localparam int unsigned CLK_HZ = 8_000_000;
   localparam int unsigned BAUD   = 1_000_000;
   localparam int unsigned BIT    = CLK_HZ / BAUD;
   localparam int unsigned TO     = 1000;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         req_valid = 1'b0;
   logic [127:0] req_data = '0;
   logic         uart_rxd = 1'b1;
   logic         req_ready, rsp_valid, rsp_timeout, cr_hazard, busy, uart_txd;
   logic [127:0] rsp_data;

   aes_uart_host #(
      .CLK_HZ        (CLK_HZ),
      .BAUD          (BAUD),
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_data   (req_data),
      .rsp_valid  (rsp_valid),
      .rsp_data   (rsp_data),
      .rsp_timeout(rsp_timeout),
      .cr_hazard  (cr_hazard),
      .busy       (busy),
      .uart_txd   (uart_txd),
      .uart_rxd   (uart_rxd)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   initial forever begin
      @(posedge clk);
      cyc++;
   end

   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0b want %0b (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic chk128(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic chki(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d want %0d", name, act, exp);
      end
   endtask

   // Model: byte i goes out i-th, starting from the most significant byte.
   function automatic logic [7:0] blk_byte(input logic [127:0] b, input int i);
      return b[(15 - i) * 8 +: 8];
   endfunction

   function automatic logic blk_cr(input logic [127:0] b);
      logic hit = 1'b0;
      for (int i = 0; i < 16; i++) if (blk_byte(b, i) == 8'h0D) hit = 1'b1;
      return hit;
   endfunction

   function automatic logic [127:0] rand_blk();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // Transmit-side serial decoder.
   logic [7:0] tx_got[$];
   logic [7:0] last_tx[16];
   int         rst_epoch = 0;
   int         mon_ep;
   logic [7:0] mon_b;
   initial forever begin
      @(negedge clk);
      if (!rst && !uart_txd) begin
         mon_ep = rst_epoch;
         repeat (BIT / 2) @(negedge clk);
         for (int i = 0; i < 8; i++) begin
            repeat (BIT) @(negedge clk);
            mon_b[i] = uart_txd;
         end
         repeat (BIT) @(negedge clk);
         if (mon_ep == rst_epoch && !rst) begin
            chk1("tx_stop_bit", uart_txd, 1'b1);
            tx_got.push_back(mon_b);
         end
      end
   end

   // Per-cycle compare against the response model.
   int           exp_rsp_cnt = 0, got_rsp_cnt = 0, exp_to_cnt = 0, got_to_cnt = 0;
   logic [127:0] exp_rsp_val = '0;
   logic [127:0] model_rsp = '0;
   int           rsp_cyc = 0, to_cyc = 0, fresh_cyc = 0;
   initial forever begin
      @(negedge clk);
      if (rst) begin
         model_rsp = '0;
      end else begin
         if (dut.rx_data_fresh) fresh_cyc = cyc;
         if (rsp_valid) begin
            chk1("rsp_valid_expected", got_rsp_cnt < exp_rsp_cnt, 1'b1);
            model_rsp = exp_rsp_val;
            got_rsp_cnt++;
            rsp_cyc = cyc;
         end
         if (rsp_timeout) begin
            chk1("rsp_timeout_expected", got_to_cnt < exp_to_cnt, 1'b1);
            got_to_cnt++;
            to_cyc = cyc;
         end
         chk1("ready_vs_busy", req_ready, ~busy);
         chk128("rsp_data_model", rsp_data, model_rsp);
      end
   end

   task automatic send_req(input logic [127:0] d);
      int n = 0;
      while (!req_ready && n < 3000) begin
         @(negedge clk);
         n++;
      end
      chk1("req_ready_before_accept", req_ready, 1'b1);
      chk1("tx_valid_idle", dut.tx_data_valid, 1'b0);
      req_data  = d;
      req_valid = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      chk1("tx_valid_after_accept", dut.tx_data_valid, 1'b1);
      chk1("busy_after_accept", busy, 1'b1);
      chk1("cr_hazard_model", cr_hazard, blk_cr(d));
   endtask

   task automatic expect_tx(input logic [127:0] d);
      int n = 0;
      while (tx_got.size() < 16 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      chki("tx_byte_count", tx_got.size(), 16);
      for (int i = 0; i < 16; i++) begin
         last_tx[i] = (i < tx_got.size()) ? tx_got[i] : 8'hxx;
         chk8($sformatf("tx_byte%0d", i), last_tx[i], blk_byte(d, i));
      end
      tx_got.delete();
   endtask

   task automatic send_byte(input logic [7:0] b);
      uart_rxd = 1'b0;
      repeat (BIT) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         uart_rxd = b[i];
         repeat (BIT) @(negedge clk);
      end
      uart_rxd = 1'b1;
      repeat (BIT) @(negedge clk);
   endtask

   task automatic send_rsp(input logic [127:0] blk, input int nbytes);
      if (nbytes == 16) begin
         exp_rsp_val = blk;
         exp_rsp_cnt++;
      end
      for (int i = 0; i < nbytes; i++) begin
         send_byte(blk_byte(blk, i));
         repeat ($urandom_range(0, 20)) @(negedge clk);
      end
   endtask

   task automatic wait_rsp();
      int n = 0;
      while (got_rsp_cnt < exp_rsp_cnt && n < 300) begin
         @(negedge clk);
         n++;
      end
      chki("rsp_arrived", got_rsp_cnt, exp_rsp_cnt);
      chki("rsp_after_last_fresh", rsp_cyc, fresh_cyc + 1);
      @(negedge clk);
      chk1("req_ready_after_rsp", req_ready, 1'b1);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk1({tag, "_req_ready"}, req_ready, 1'b1);
      chk1({tag, "_rsp_valid"}, rsp_valid, 1'b0);
      chk1({tag, "_rsp_timeout"}, rsp_timeout, 1'b0);
      chk1({tag, "_cr_hazard"}, cr_hazard, 1'b0);
      chk1({tag, "_busy"}, busy, 1'b0);
      chk128({tag, "_rsp_data"}, rsp_data, 128'h0);
      chk1({tag, "_txd"}, uart_txd, 1'b1);
   endtask

   initial begin
      #800_000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   logic [127:0] d, r;
   int           acks, n;
   initial begin
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (5) @(negedge clk);
      rst = 1'b1;
      rst_epoch++;
      #1;
      check_reset_outputs("reset_idle");
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check_reset_outputs("after_reset");

      // Transmit order and response assembly with fixed vectors.
      d = 128'h00112233445566778899AABBCCDDEEFF;
      send_req(d);
      chk1("cr_hazard_clear_literal", cr_hazard, 1'b0);
      expect_tx(d);
      chk8("tx_first_literal", last_tx[0], 8'h00);
      chk8("tx_mid_literal", last_tx[10], 8'hAA);
      chk8("tx_last_literal", last_tx[15], 8'hFF);
      send_rsp(128'h69C4E0D86A7B0430D8CDB78070B4C55A, 16);
      wait_rsp();
      chk128("rsp_literal", rsp_data, 128'h69C4E0D86A7B0430D8CDB78070B4C55A);

      // Timeout after only five reply bytes.
      send_req(rand_blk());
      expect_tx(req_data);
      send_rsp(rand_blk(), 5);
      exp_to_cnt++;
      n = 0;
      while (got_to_cnt < exp_to_cnt && n < TO + 300) begin
         @(negedge clk);
         n++;
      end
      chki("timeout_seen", got_to_cnt, exp_to_cnt);
      chki("timeout_delay", to_cyc - fresh_cyc, TO);
      chk128("rsp_data_kept_literal", rsp_data, 128'h69C4E0D86A7B0430D8CDB78070B4C55A);
      @(negedge clk);
      chk1("req_ready_after_timeout", req_ready, 1'b1);

      // Carriage-return hazard still sends all 16 bytes.
      d = 128'h0011220D445566778899AABBCCDDEEFF;
      send_req(d);
      chk1("cr_hazard_literal", cr_hazard, 1'b1);
      expect_tx(d);
      chk8("tx_cr_literal", last_tx[3], 8'h0D);
      send_rsp(rand_blk(), 16);
      wait_rsp();

      // Randomized exchanges, with a stray byte arriving while idle.
      for (int it = 0; it < 4; it++) begin
         send_byte(8'($urandom));
         repeat (6) @(negedge clk);
         d = rand_blk();
         if ($urandom_range(0, 1) == 1) d[$urandom_range(0, 15) * 8 +: 8] = 8'h0D;
         send_req(d);
         expect_tx(d);
         r = rand_blk();
         send_rsp(r, 16);
         wait_rsp();
      end

      // Reset in the middle of SEND.
      send_req(rand_blk());
      acks = 0;
      n = 0;
      while (acks < 7 && n < 3000) begin
         @(posedge clk);
         #1;
         if (dut.tx_data_ack) acks++;
         n++;
      end
      chki("acks_before_reset", acks, 7);
      rst = 1'b1;
      rst_epoch++;
      #1;
      check_reset_outputs("reset_mid_send");
      tx_got.delete();
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (120) @(negedge clk);
      tx_got.delete();
      d = rand_blk();
      send_req(d);
      expect_tx(d);
      send_rsp(rand_blk(), 16);
      wait_rsp();

      repeat (5) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
